// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin arbiter that sequences one command at a time into
// the shared I2C master. It waits for completion or timeout, then reports done/err to the owner.
module i2c_req_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 6,
    parameter int TIMEOUT   = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     req_valid,
    input  logic [1:0]                     req_rw,
    input  logic [2*ADDRWIDTH-1:0]         req_addr,
    input  logic [2*DATAWIDTH-1:0]         req_data,
    input  logic [2*$clog2(DATAWIDTH)-1:0] req_shift,
    input  logic [1:0]                     req_msbin,
    input  logic [1:0]                     req_lsbin,
    output logic [1:0]                     req_ack,
    output logic [1:0]                     req_done,
    output logic                           req_err,
    output logic                           m_wr_en,
    output logic                           m_rd_en,
    output logic [ADDRWIDTH-1:0]           m_addr,
    output logic [DATAWIDTH-1:0]           m_D,
    output logic [$clog2(DATAWIDTH)-1:0]   m_S,
    output logic                           m_MSBIn,
    output logic                           m_LSBIn,
    input  logic                           m_done,
    output logic                           busy
);

    localparam int SW = $clog2(DATAWIDTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      ack_q, ack_d;
    logic [1:0]      done_q, done_d;
    logic            err_q, err_d;
    logic            wr_en_q, wr_en_d;
    logic            rd_en_q, rd_en_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            msbin_q, msbin_d;
    logic            lsbin_q, lsbin_d;
    logic            busy_q, busy_d;
    logic            sel;

    // Contention goes to the pointer; a lone requester wins outright.
    assign sel = (req_valid == 2'b11) ? ptr_q : req_valid[1];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        shift_d = shift_q;
        msbin_d = msbin_q;
        lsbin_d = lsbin_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d = sel;
                    addr_d  = sel ? req_addr[2*ADDRWIDTH-1:ADDRWIDTH] : req_addr[ADDRWIDTH-1:0];
                    data_d  = sel ? req_data[2*DATAWIDTH-1:DATAWIDTH] : req_data[DATAWIDTH-1:0];
                    shift_d = sel ? req_shift[2*SW-1:SW] : req_shift[SW-1:0];
                    msbin_d = req_msbin[sel];
                    lsbin_d = req_lsbin[sel];
                    ack_d   = sel ? 2'b10 : 2'b01;
                    wr_en_d = ~req_rw[sel];
                    rd_en_d = req_rw[sel];
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The counter tracks cycles elapsed since the ISSUE cycle.
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_done) begin
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                ptr_d   = ~grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            shift_q <= '0;
            msbin_q <= 1'b0;
            lsbin_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            msbin_q <= msbin_d;
            lsbin_q <= lsbin_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ack  = ack_q;
    assign req_done = done_q;
    assign req_err  = err_q;
    assign m_wr_en  = wr_en_q;
    assign m_rd_en  = rd_en_q;
    assign m_addr   = addr_q;
    assign m_D      = data_q;
    assign m_S      = shift_q;
    assign m_MSBIn  = msbin_q;
    assign m_LSBIn  = lsbin_q;
    assign busy     = busy_q;

endmodule
